// File: rtl/ysyx_25040101_defs.sv
// Shared definitions for the SRAM responder and its requester: transfer size
// encodings, responder FSM states and small helpers.
package ysyx_25040101_defs;

    typedef enum logic [1:0] {
        SZ_1B  = 2'b00,
        SZ_2B  = 2'b01,
        SZ_4B  = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Latency counter width; covers LATENCY-1 for LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

    function automatic int unsigned size_bytes(input logic [1:0] size);
        case (size)
            SZ_1B:   return 1;
            SZ_2B:   return 2;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25040101_pmem.sv
// Simulation memory model behind the responder. Storage is sparse and byte
// addressed; the call counters let a requester-side environment confirm how
// many accesses reached memory.
package ysyx_25040101_pmem;

    logic [7:0]  mem [logic [31:0]];
    int unsigned read_calls;
    int unsigned write_calls;

    function automatic logic [31:0] pmem_read(input logic [31:0] addr,
                                              input int unsigned nbytes,
                                              input logic        sext);
        logic [31:0] v;
        v = '0;
        read_calls++;
        for (int unsigned i = 0; i < nbytes; i++) begin
            v[8*i +: 8] = mem.exists(addr + i) ? mem[addr + i] : 8'h00;
        end
        if (sext && nbytes < 4 && v[8*nbytes-1]) begin
            v = v | (32'hFFFF_FFFF << (8*nbytes));
        end
        return v;
    endfunction

    function automatic void pmem_write(input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       input int unsigned nbytes);
        write_calls++;
        for (int unsigned i = 0; i < nbytes; i++) begin
            mem[addr + i] = wdata[8*i +: 8];
        end
    endfunction

endpackage

// File: rtl/ysyx_25040101_align_chk.sv
// Alignment and size legality check for a single memory request.
module ysyx_25040101_align_chk
    import ysyx_25040101_defs::*;
(
    input  logic [1:0] addr_i,
    input  logic [1:0] size_i,
    output logic       err_o
);

    // Halfwords need even addresses, words need 4-byte alignment, 2'b11 is illegal.
    always_comb begin
        err_o = 1'b0;
        case (size_i)
            SZ_1B:   err_o = 1'b0;
            SZ_2B:   err_o = addr_i[0];
            SZ_4B:   err_o = |addr_i;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25040101_sram_resp.sv
// SRAM responder: accepts one request in IDLE, waits LATENCY edges, performs
// the memory access at the final edge and holds the response until taken.
module ysyx_25040101_sram_resp
    import ysyx_25040101_defs::*;
    import ysyx_25040101_pmem::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_sext_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic             sext_q, sext_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             access;
    logic             chk_err;

    ysyx_25040101_align_chk u_align_chk (
        .addr_i (addr_q[1:0]),
        .size_i (size_q),
        .err_o  (chk_err)
    );

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // Next-state logic: request capture, latency countdown, response handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sext_d  = sext_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    size_d  = req_size_i;
                    sext_d  = req_sext_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access  = 1'b1;
                    err_d   = chk_err;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and captured-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            err_q   <= err_d;
        end
    end

    // Memory access at the final wait edge; the memory call has side effects,
    // so it lives here rather than in the combinational next-state block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (access && !chk_err) begin
            if (we_q) begin
                pmem_write(addr_q, wdata_q, size_bytes(size_q));
                rdata_q <= '0;
            end else begin
                rdata_q <= pmem_read(addr_q, size_bytes(size_q), sext_q);
            end
        end else if (access) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040101_sram_resp.sv
// Self-checking bench for the SRAM responder: directed scenarios plus random
// transactions against a byte-level reference memory, on LATENCY=1 and 4.
module tb_ysyx_25040101_sram_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid1, req_valid4;
    logic        req_we, req_sext, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rr1, rv1, re1, rr4, rv4, re4;
    logic [31:0] rd1, rd4;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_rc   = 0;
    int unsigned exp_wc   = 0;
    logic [7:0]  ref_mem [logic [31:0]];

    always #5 clk = ~clk;

    ysyx_25040101_sram_resp #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid1), .req_ready_o(rr1), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
        .req_sext_i(req_sext), .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rd1), .rsp_err_o(re1)
    );

    ysyx_25040101_sram_resp #(.LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid4), .req_ready_o(rr4), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
        .req_sext_i(req_sext), .rsp_valid_o(rv4), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rd4), .rsp_err_o(re4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] o_valid(input bit l4);
        return {31'b0, (l4 ? rv4 : rv1)};
    endfunction
    function automatic logic [31:0] o_ready(input bit l4);
        return {31'b0, (l4 ? rr4 : rr1)};
    endfunction
    function automatic logic [31:0] o_err(input bit l4);
        return {31'b0, (l4 ? re4 : re1)};
    endfunction
    function automatic logic [31:0] o_rdata(input bit l4);
        return l4 ? rd4 : rd1;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Reference behaviour: an n-byte access must be n-aligned, 2'b11 is illegal.
    task automatic model_access(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic sext, output logic [31:0] rdata,
                                output logic err);
        int unsigned     n;
        longint unsigned val;
        n     = 1 << size;
        err   = (size == 2'b11) || ((addr % n) != 0);
        rdata = '0;
        val   = 0;
        if (err) return;
        if (we) begin
            exp_wc++;
            for (int unsigned k = 0; k < n; k++) ref_mem[addr + k] = 8'(wdata >> (8*k));
        end else begin
            exp_rc++;
            for (int unsigned k = 0; k < n; k++) val += longint'(ref_byte(addr + k)) << (8*k);
            if (sext && n < 4 && val >= (64'd1 << (8*n - 1)))
                val += (64'd1 << 32) - (64'd1 << (8*n));
            rdata = 32'(val);
        end
    endtask

    task automatic do_txn(input bit l4, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic sext, input int unsigned hold,
                          output logic [31:0] got);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int unsigned lat, edges;
        lat = l4 ? 4 : 1;
        model_access(we, addr, wdata, size, sext, exp_rdata, exp_err);
        check("req_ready_idle", o_ready(l4), 32'd1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_sext = sext;
        if (l4) req_valid4 = 1'b1; else req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0; req_valid4 = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_sext = 1'($urandom);
        edges = 0;
        while (o_valid(l4) == 32'd0 && edges < 32) begin
            check("req_ready_busy", o_ready(l4), 32'd0);
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, lat);
        check("rdata", o_rdata(l4), exp_rdata);
        check("err", o_err(l4), {31'b0, exp_err});
        got = o_rdata(l4);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", o_valid(l4), 32'd1);
            check("hold_rdata", o_rdata(l4), exp_rdata);
            check("hold_err", o_err(l4), {31'b0, exp_err});
            check("hold_ready", o_ready(l4), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("valid_drop", o_valid(l4), 32'd0);
        check("ready_back", o_ready(l4), 32'd1);
        check("read_calls", ysyx_25040101_pmem::read_calls, exp_rc);
        check("write_calls", ysyx_25040101_pmem::write_calls, exp_wc);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid1", 32'(rv1), 32'd0);
        check("rst_valid4", 32'(rv4), 32'd0);
        check("rst_rdata4", rd4, 32'd0);
        check("rst_err4", 32'(re4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready1", 32'(rr1), 32'd1);
        check("rst_ready4", 32'(rr4), 32'd1);
    endtask

    initial begin
        logic [31:0] got, tmp_rdata;
        logic        tmp_err;
        bit          l4;
        rst_n = 1'b0;
        req_valid1 = 1'b0; req_valid4 = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_sext = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid1", 32'(rv1), 32'd0);
        check("reset_rdata1", rd1, 32'd0);
        check("reset_err1", 32'(re1), 32'd0);
        check("reset_valid4", 32'(rv4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_ready1", 32'(rr1), 32'd1);
        check("reset_ready4", 32'(rr4), 32'd1);

        // LATENCY=1 directed scenarios.
        do_txn(1'b0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, got);
        check("wr_rdata_zero", got, 32'd0);
        do_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 2'b10, 1'b0, 0, got);
        check("rd_word", got, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b0, 32'h8000_0003, 32'h0, 2'b00, 1'b1, 0, got);
        check("rd_byte_sext", got, 32'hFFFF_FFDE);
        do_txn(1'b0, 1'b0, 32'h8000_0003, 32'h0, 2'b00, 1'b0, 0, got);
        check("rd_byte_zext", got, 32'h0000_00DE);
        do_txn(1'b0, 1'b0, 32'h8000_0001, 32'h0, 2'b01, 1'b0, 0, got);
        do_txn(1'b0, 1'b1, 32'h8000_0002, 32'h1111_2222, 2'b10, 1'b0, 0, got);
        do_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 2'b11, 1'b0, 0, got);
        do_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 2'b10, 1'b0, 0, got);
        check("mem_unchanged", got, 32'hDEAD_BEEF);

        // LATENCY=4 with a stalled response.
        do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 2'b01, 1'b1, 5, got);
        check("rd_half_sext", got, 32'hFFFF_BEEF);

        // Reset while waiting discards the write.
        do_txn(1'b1, 1'b1, 32'h8000_0010, 32'hA5A5_5A5A, 2'b10, 1'b0, 0, got);
        req_we = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h1234_5678;
        req_size = 2'b10; req_sext = 1'b0; req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_busy", 32'(rr4), 32'd0);
        pulse_reset();
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_write", ysyx_25040101_pmem::write_calls, exp_wc);
        do_txn(1'b1, 1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0, 0, got);
        check("rst_old_value", got, 32'hA5A5_5A5A);

        // Reset while the response is pending drops it.
        model_access(1'b0, 32'h8000_0000, 32'h0, 2'b10, 1'b0, tmp_rdata, tmp_err);
        req_we = 1'b0; req_addr = 32'h8000_0000; req_size = 2'b10; req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        @(posedge clk); #1;
        check("resp_pending", 32'(rv1), 32'd1);
        check("resp_pending_data", rd1, tmp_rdata);
        pulse_reset();

        // Random traffic on both latencies.
        for (int i = 0; i < 40; i++) begin
            l4 = 1'($urandom);
            do_txn(l4, 1'($urandom), 32'h8000_0000 + $urandom_range(0, 15), $urandom,
                   2'($urandom), 1'($urandom), $urandom_range(0, 3), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/ysyx_25040101_sram_resp.md
YSYX_25040101_SRAM_RESP -- requirements
Module: ysyx_25040101_sram_resp

Interface
REQ-001 Parameter: LATENCY, default 1, clock edges from request acceptance to response valid; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid_i  input  1  requester holds a valid request.
REQ-005 Port: req_ready_o  output  1  responder can accept a request.
REQ-006 Port: req_we_i  input  1  1 = write, 0 = read.
REQ-007 Port: req_addr_i  input  32  byte address.
REQ-008 Port: req_wdata_i  input  32  write data, LSB-aligned.
REQ-009 Port: req_size_i  input  2  00 = 1B, 01 = 2B, 10 = 4B, 11 = illegal.
REQ-010 Port: req_sext_i  input  1  sign-extend read data; ignored for 4B and for writes.
REQ-011 Port: rsp_valid_o  output  1  response available.
REQ-012 Port: rsp_ready_i  input  1  requester accepts the response.
REQ-013 Port: rsp_rdata_o  output  32  read data; 0 for writes and errors.
REQ-014 Port: rsp_err_o  output  1  request was misaligned or illegal size.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; IDLE is the only state with req_ready_o = 1.
REQ-016 IDLE: on req_valid_i & req_ready_o at an edge, latch we, addr, wdata, size and sext, load the latency counter with LATENCY-1, and go to WAIT.
REQ-017 WAIT: if counter != 0, decrement it and stay; if counter == 0, perform the access and go to RESP.
REQ-018 rsp_valid_o rises exactly LATENCY rising edges after the accepting edge.
REQ-019 Read access: exactly one pmem_read(addr, nbytes, sext) DPI call at that edge; the result is registered into rsp_rdata_o.
REQ-020 Write access: exactly one pmem_write(addr, wdata, nbytes) DPI call at that edge; only the low nbytes of wdata are significant; rsp_rdata_o = 0.
REQ-021 Error condition: 2B with addr[0] = 1, 4B with addr[1:0] != 0, or size = 11.
REQ-022 On error: no DPI call is made; rsp_err_o = 1; rsp_rdata_o = 0; latency is unchanged.
REQ-023 RESP: rsp_valid_o, rsp_rdata_o and rsp_err_o hold stable until rsp_ready_i is sampled high; on that edge, rsp_valid_o goes to 0 and the FSM returns to IDLE.
REQ-024 New requests are not accepted in the cycle the response handshake completes; minimum spacing between acceptances is LATENCY+2 cycles.
REQ-025 Request inputs are ignored outside IDLE; changes to them after acceptance do not affect the transaction in flight.
REQ-026 DPI calls occur only inside a clocked process and never in combinational logic.

Reset
REQ-027 While rst_n = 0: state = IDLE, counter = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0; req_ready_o = 1 after release.
REQ-028 Reset asserted in WAIT before the access edge discards the transaction: no DPI call is made and memory is unchanged.
REQ-029 Reset asserted in RESP drops the pending response without a handshake.

Structure
REQ-030 Size encodings (SZ_1B, SZ_2B, SZ_4B) and FSM state encodings reside in the shared defines package ysyx_25040101_defs, reused by the requester side.
REQ-031 Alignment/size legality check is the one natural sub-module: ysyx_25040101_align_chk (combinational; inputs addr[1:0] and size; output err).
REQ-032 Target size is 120-400 lines of RTL; no memory array inside the block (storage stays in the DPI model).

Verification
REQ-033 Scenario: LATENCY=1; write 4B 0xDEADBEEF to 0x80000000, then read 4B from the same address -> rsp_valid_o one edge after each acceptance; read rdata = 0xDEADBEEF; err = 0.
REQ-034 Scenario: read 1B at 0x80000003 with sext=1 after the write above -> rdata = 0xFFFFFFDE; with sext=0 -> rdata = 0x000000DE.
REQ-035 Scenario: 2B read at 0x80000001, and 4B write at 0x80000002 -> err = 1, rdata = 0, memory unchanged, no DPI call recorded.
REQ-036 Scenario: LATENCY=4; rsp_ready_i held 0 for 5 cycles -> response appears 4 edges after acceptance, outputs stay stable, req_ready_o stays 0, returns to IDLE on the ready edge.
REQ-037 Scenario: LATENCY=4; 4B write of 0x12345678, rst_n pulsed low 2 edges after acceptance -> outputs zero immediately, memory unchanged, next read returns the old value.
